cpu64_obi_receiver_mo: RTL and testbench
========================================

Name: cpu64_obi_receiver_mo

Overview:
Multi-outstanding successor to the single-outstanding OBI receiver shim between the core-side OBI host and the L1 CPU-side port. Accepts up to DEPTH requests in flight and returns responses to the core strictly in request order. Stores get a locally generated response; loads get L1 read data. A response buffer with rready backpressure decouples the core from L1 return timing. A sticky flag reports unexpected L1 responses.

Parameters:
CORE_ADDR_W, 39, core-side address width; zero-extended to 64 bits toward L1.
DATA_W, 64, data width; must be 64.
DEPTH, 4, maximum slots allocated and not yet popped; power of 2, at least 2.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
req_i  in  1  core request valid.
we_i  in  1  core write enable.
be_i  in  8  byte enables.
addr_i  in  CORE_ADDR_W  core address.
wdata_i  in  DATA_W  write data.
gnt_o  out  1  request accepted this cycle.
rvalid_o  out  1  response valid at the head of the buffer.
rready_i  in  1  core accepts the response.
rdata_o  out  DATA_W  response data; 0 for stores.
l1_req_o  out  1  request to L1.
l1_we_o  out  1  pass-through of we_i.
l1_be_o  out  8  pass-through of be_i.
l1_addr_o  out  64  addr_i zero-extended.
l1_wdata_o  out  64  pass-through of wdata_i.
l1_gnt_i  in  1  L1 grant.
l1_rvalid_i  in  1  L1 read data valid; reads only, in order.
l1_rdata_i  in  64  L1 read data.
occupancy_o  out  CNT_W  allocated slots.
rsp_err_o  out  1  sticky: l1_rvalid_i seen with no pending load.

Behaviour:
- Reset (rst_i=1, async): all slot-valid bits, pointers, occupancy and rsp_err_o go to 0. As a result rvalid_o=0, rdata_o=0, occupancy_o=0, rsp_err_o=0 and l1_req_o=0. Reset mid-transaction drops all in-flight state. L1 responses for dropped loads that arrive after reset release raise rsp_err_o.
- Storage: circular buffer of DEPTH slots {valid, data}, with alloc_ptr and head_ptr. A separate DEPTH-entry FIFO holds the slot indices of pending loads (ld_q).
- Issue: l1_req_o = req_i & (occupancy_q < DEPTH). gnt_o = l1_req_o & l1_gnt_i. Address, be, we and wdata are combinational pass-throughs.
- On gnt_o, the slot at alloc_ptr is allocated and alloc_ptr increments modulo DEPTH:
  - Store: slot valid=1, data=0 at the next edge.
  - Load: slot valid=0, and the slot index is pushed into ld_q.
- On l1_rvalid_i with ld_q non-empty: the slot at the ld_q head gets valid=1 and data=l1_rdata_i, and ld_q pops.
- On l1_rvalid_i with ld_q empty (checked before this cycle's push): rsp_err_o<=1 and the data is discarded. A same-cycle load grant never satisfies this response; L1 read latency is at least 1 cycle.
- Response: rvalid_o = valid[head_ptr] and rdata_o = data[head_ptr]; both are registered-slot outputs with no combinational L1-to-core path.
- Pop on rvalid_o & rready_i: clear valid[head_ptr] and increment head_ptr modulo DEPTH.
- Latency: a store granted at cycle t gives rvalid_o at t+1 when it is at the head. l1_rvalid_i at t gives rvalid_o at t+1 when that slot is at the head.
- Ordering: a younger completed store is held until all older loads have been popped.
- occupancy_q next = occupancy_q + alloc − pop. When full, a pop in a cycle does not enable an allocation in the same cycle (no bypass); allocation is possible from the next cycle.
- Core holding rvalid/rready low indefinitely: the buffer fills and l1_req_o deasserts. Nothing is lost.
- Pointer wrap: alloc_ptr and head_ptr wrap independently. full/empty are derived from occupancy_q, not from pointer equality.

Test Plan:
- Reset/idle: rst_i=1 mid-run → all outputs 0 within the same cycle. After release, a read to 0x100 issues with l1_addr_o=0x0000000000000100.
- Back-to-back loads: 4 loads granted at t0..t3 with L1 data 0xA..0xD at t2..t5, rready_i=1 → rvalid_o at t3..t6 with 0xA..0xD; occupancy_o peaks at 3 or 4.
- Mixed order: load(A), store, load(B) granted consecutively, L1 returns A after 5 cycles → the store response (rdata_o=0) is emitted only after A is popped; sequence is A, 0, B.
- Backpressure/full: rready_i=0 with DEPTH=4 stores granted → l1_req_o=0 while req_i=1 and occupancy_o=4. One pop → gnt_o possible the following cycle, never the same cycle.
- Wrap: 3×DEPTH alternating loads/stores with random rready_i → responses are exactly in grant order and no slot is lost or duplicated.
- Error: l1_rvalid_i=1 with no load pending → rsp_err_o=1, rvalid_o unaffected, flag remains set until rst_i.

Source files
------------

// File: rtl/cpu64_obi_receiver_mo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cpu64_obi_receiver_mo: multi-outstanding in-order OBI receiver shim to L1.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module cpu64_obi_receiver_mo #(
    parameter int CORE_ADDR_W = 39,
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [7:0]             be_i,
    input  logic [CORE_ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   l1_req_o,
    output logic                   l1_we_o,
    output logic [7:0]             l1_be_o,
    output logic [63:0]            l1_addr_o,
    output logic [63:0]            l1_wdata_o,
    input  logic                   l1_gnt_i,
    input  logic                   l1_rvalid_i,
    input  logic [63:0]            l1_rdata_i,
    output logic [CNT_W-1:0]       occupancy_o,
    output logic                   rsp_err_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  slot_valid;
    logic [DATA_W-1:0] slot_data [DEPTH];
    logic [PTR_W-1:0]  alloc_ptr;
    logic [PTR_W-1:0]  head_ptr;
    logic [CNT_W-1:0]  occupancy_q;

    logic [PTR_W-1:0]  ld_q [DEPTH];
    logic [PTR_W-1:0]  ld_wr_ptr;
    logic [PTR_W-1:0]  ld_rd_ptr;
    logic [CNT_W-1:0]  ld_cnt;
    logic              rsp_err_q;

    logic full;
    logic alloc;
    logic pop;
    logic ld_push;
    logic ld_pop;
    logic ld_empty;

    assign full     = (occupancy_q == FULL_CNT);
    // Gating with reset keeps the L1 request quiet while reset is asserted.
    assign l1_req_o = req_i & ~rst_i & ~full;
    assign gnt_o    = l1_req_o & l1_gnt_i;
    assign alloc    = gnt_o;
    assign pop      = rvalid_o & rready_i;
    assign ld_push  = alloc & ~we_i;
    assign ld_empty = (ld_cnt == '0);
    assign ld_pop   = l1_rvalid_i & ~ld_empty;

    assign l1_we_o     = we_i;
    assign l1_be_o     = be_i;
    assign l1_addr_o   = {{(64 - CORE_ADDR_W){1'b0}}, addr_i};
    assign l1_wdata_o  = wdata_i;

    assign rvalid_o    = slot_valid[head_ptr];
    assign rdata_o     = slot_data[head_ptr];
    assign occupancy_o = occupancy_q;
    assign rsp_err_o   = rsp_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_data[i] <= '0;
            end
            alloc_ptr   <= '0;
            head_ptr    <= '0;
            occupancy_q <= '0;
            ld_wr_ptr   <= '0;
            ld_rd_ptr   <= '0;
            ld_cnt      <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (pop) begin
                slot_valid[head_ptr] <= 1'b0;
                head_ptr             <= head_ptr + 1'b1;
            end
            if (alloc) begin
                slot_valid[alloc_ptr] <= we_i;
                if (we_i) begin
                    slot_data[alloc_ptr] <= '0;
                end
                alloc_ptr <= alloc_ptr + 1'b1;
            end
            if (ld_push) begin
                ld_wr_ptr <= ld_wr_ptr + 1'b1;
            end
            // Emptiness is judged before this cycle's push: a same-cycle load cannot be answered.
            if (ld_pop) begin
                slot_valid[ld_q[ld_rd_ptr]] <= 1'b1;
                slot_data[ld_q[ld_rd_ptr]]  <= l1_rdata_i;
                ld_rd_ptr                   <= ld_rd_ptr + 1'b1;
            end else if (l1_rvalid_i) begin
                rsp_err_q <= 1'b1;
            end
            ld_cnt      <= ld_cnt + CNT_W'(ld_push) - CNT_W'(ld_pop);
            occupancy_q <= occupancy_q + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (ld_push) begin
            ld_q[ld_wr_ptr] <= alloc_ptr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu64_obi_receiver_mo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_cpu64_obi_receiver_mo: randomized in-order response check vs. a model.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_cpu64_obi_receiver_mo;

    localparam int DEPTH = 4;
    localparam int AW    = 39;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, we = 1'b0, rready = 1'b0;
    logic [7:0]  be = '0;
    logic [AW-1:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        gnt, rvalid, l1_req, l1_we;
    logic [63:0] rdata, l1_addr, l1_wdata;
    logic [7:0]  l1_be;
    logic        l1_gnt = 1'b0, l1_rvalid = 1'b0;
    logic [63:0] l1_rdata = '0;
    logic [2:0]  occupancy;
    logic        rsp_err;

    always #5 clk = ~clk;

    cpu64_obi_receiver_mo #(.CORE_ADDR_W(AW), .DATA_W(64), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
        .l1_req_o(l1_req), .l1_we_o(l1_we), .l1_be_o(l1_be), .l1_addr_o(l1_addr),
        .l1_wdata_o(l1_wdata), .l1_gnt_i(l1_gnt), .l1_rvalid_i(l1_rvalid),
        .l1_rdata_i(l1_rdata), .occupancy_o(occupancy), .rsp_err_o(rsp_err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference: responses indexed by grant sequence number, completed flag plus data.
    bit          m_done [1024];
    logic [63:0] m_data [1024];
    int          m_head = 0, m_tail = 0;
    int          m_loads[$];
    bit          m_err = 0;

    typedef struct { int t; logic [63:0] d; } l1_rsp_t;
    l1_rsp_t     l1q[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit w, input logic [AW-1:0] a, input logic [63:0] wd,
                         input logic [7:0] b, input bit g, input bit rr, input bit lv,
                         input logic [63:0] ld);
        bit exp_req, exp_gnt, exp_rv;
        int occ;
        @(negedge clk);
        req = r; we = w; addr = a; wdata = wd; be = b;
        l1_gnt = g; rready = rr; l1_rvalid = lv; l1_rdata = ld;
        #1;
        occ     = m_tail - m_head;
        exp_req = r && (occ < DEPTH);
        exp_gnt = exp_req && g;
        exp_rv  = (occ > 0) && m_done[m_head % 1024];
        check_val("l1_req", {63'b0, l1_req}, {63'b0, exp_req});
        check_val("gnt", {63'b0, gnt}, {63'b0, exp_gnt});
        check_val("rvalid", {63'b0, rvalid}, {63'b0, exp_rv});
        if (exp_rv) check_val("rdata", rdata, m_data[m_head % 1024]);
        check_val("occupancy", {61'b0, occupancy}, 64'(occ));
        check_val("rsp_err", {63'b0, rsp_err}, {63'b0, m_err});
        check_val("l1_addr", l1_addr, {25'b0, a});
        check_val("l1_pass", {l1_wdata[55:0], l1_be}, {wd[55:0], b});
        check_val("l1_we", {63'b0, l1_we}, {63'b0, w});
        @(posedge clk);
        if (lv) begin
            if (m_loads.size() > 0) begin
                int s = m_loads.pop_front();
                m_done[s % 1024] = 1'b1;
                m_data[s % 1024] = ld;
            end else begin
                m_err = 1'b1;
            end
        end
        if (exp_gnt) begin
            m_done[m_tail % 1024] = w;
            m_data[m_tail % 1024] = 64'd0;
            if (!w) begin
                l1_rsp_t e;
                m_loads.push_back(m_tail);
                e.t = cyc + 1 + int'($urandom_range(0, 4));
                e.d = {$urandom, $urandom};
                l1q.push_back(e);
            end
            m_tail++;
        end
        if (exp_rv && rr) m_head++;
        cyc++;
    endtask

    // One cycle whose L1 side is driven by the in-order L1 model.
    task automatic rand_cycle(input bit r, input bit w, input bit rr);
        bit lv = 1'b0;
        logic [63:0] ld = '0;
        if (l1q.size() > 0 && l1q[0].t <= cyc && ($urandom % 4) != 0) begin
            lv = 1'b1;
            ld = l1q[0].d;
            void'(l1q.pop_front());
        end
        cycle(r, w, AW'({$urandom, $urandom}), {$urandom, $urandom}, 8'($urandom),
              ($urandom % 4) != 0, rr, lv, ld);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_tail != m_head || l1q.size() > 0) && n < 300) begin
            rand_cycle(1'b0, 1'b0, 1'b1);
            n++;
        end
        check_val("drain_done", 64'(m_tail - m_head), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b1; l1_rvalid = 1'b0; rready = 1'b0;
        #1;
        check_val("rst_rvalid", {63'b0, rvalid}, 64'd0);
        check_val("rst_rdata", rdata, 64'd0);
        check_val("rst_occ", {61'b0, occupancy}, 64'd0);
        check_val("rst_err", {63'b0, rsp_err}, 64'd0);
        check_val("rst_l1_req", {63'b0, l1_req}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        m_head = 0; m_tail = 0; m_err = 1'b0;
        m_loads.delete(); l1q.delete();
    endtask

    initial begin
        do_reset();
        cycle(1'b1, 1'b0, 39'h100, 64'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 64'd0);
        drain();

        // Back-to-back loads with the core always ready.
        repeat (4) cycle(1'b1, 1'b0, AW'($urandom), 64'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 64'd0);
        drain();

        // Mixed load/store/load: the store response waits behind the older load.
        cycle(1'b1, 1'b0, 39'h200, 64'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 39'h208, 64'h55, 8'hFF, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, 39'h210, 64'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 64'd0);
        drain();

        // Fill with stores under backpressure, then a single pop: no same-cycle refill.
        repeat (6) cycle(1'b1, 1'b1, AW'($urandom), 64'd1, 8'h0F, 1'b1, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 39'h40, 64'd2, 8'h0F, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 39'h48, 64'd3, 8'h0F, 1'b1, 1'b0, 1'b0, 64'd0);
        drain();

        // Randomized mixed traffic with random backpressure and wrap-around.
        for (int i = 0; i < 400; i++) begin
            rand_cycle(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) != 0);
        end

        // Reset in the middle of traffic drops everything in flight.
        for (int i = 0; i < 10; i++) rand_cycle(1'b1, $urandom % 2, 1'b0);
        do_reset();
        cycle(1'b1, 1'b0, 39'h100, 64'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 64'd0);
        drain();

        // Unexpected L1 response: sticky error, response path untouched.
        cycle(1'b0, 1'b0, 39'h0, 64'd0, 8'h00, 1'b0, 1'b1, 1'b1, 64'hDEAD);
        for (int i = 0; i < 20; i++) rand_cycle(($urandom % 2) != 0, $urandom % 2, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
